ff_processor_set: RTL
=====================

# ff_processor_set

Feedforward counterpart of the backprop processor set. Each cycle it takes `z` activations and `z` weights, forms `z/fi` neuron pre-activations by multiplying lane-wise and summing groups of `fi` products, adds a per-neuron bias and applies a saturating ReLU. It emits the activation `a_out` and its derivative `adot_out`; the BP processor set later consumes `adot_out` as `adot_out_package`. The datapath is a fixed-latency, non-stalling pipeline with valid tracking.

## Interface
- `z`, 32, weights and activations processed per cycle; must be a multiple of `fi`.
- `fi`, 16, fan-in group size per neuron per cycle; must be a power of 2, at least 2.
- `width`, 10, bit width of every fixed-point value.
- `int_bits`, 2, integer bits. Format is signed two's complement: 1 sign bit, `int_bits` integer bits, `F = width-1-int_bits` fraction bits. Defaults give F=7, so 1.0 = 0x080.

Ports:
- `clk`  in  1  clock; all registers update on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `valid_in`  in  1  input packages are valid this cycle.
- `a_in_package`  in  width*z  activation lanes; lane k occupies bits [width*(k+1)-1 : width*k].
- `wt_package`  in  width*z  weight lanes, packed the same way as `a_in_package`.
- `bias_package`  in  width*z/fi  neuron biases; neuron n occupies bits [width*(n+1)-1 : width*n].
- `a_out_package`  out  width*z/fi  activations, packed per neuron.
- `adot_out_package`  out  width*z/fi  activation derivatives, packed per neuron.
- `valid_out`  out  1  output packages are valid this cycle.

## Operation
- Neuron n uses lanes n*fi through n*fi+fi-1.
- **Stage M (multiply):**
  - p_k = (a_k * w_k) as a full 2*width-bit signed product.
  - Arithmetic shift right by F, which truncates toward minus infinity.
  - Saturate to width bits: max 2^(width-1)-1, min -2^(width-1).
  - Register the result.
- **Stages T1 through T(log2 fi) (adder tree):**
  - Each stage adds adjacent pairs and registers the sums.
  - Accumulators are width+log2(fi) bits wide, so no intermediate overflow or saturation occurs.
- **Stage A (activation):**
  - s = tree_sum + sign-extended bias.
  - Saturate s to width bits.
  - a_out = s if s > 0, else 0.
  - adot_out = 1.0 (1 << F) if s > 0, else 0. A saturated positive s still gives adot 1.0.
  - Register the result.
- A valid bit travels alongside the data through every stage.
- Data registers may load unconditionally. Outputs are only meaningful when `valid_out` = 1.
- There is no backpressure: a new input may be accepted every cycle.
- **Reset (`reset` = 0):**
  - Asynchronously clears all valid bits and all data registers.
  - `a_out_package`, `adot_out_package` and `valid_out` go to 0 immediately, without waiting for a clock edge.
  - Data in flight is discarded and never appears at the outputs.
- Inputs present while `reset` = 0 are ignored. The first sample is taken on the first rising edge after `reset` = 1.

## Timing
- Latency L = log2(fi) + 2 cycles, which is 6 for defaults.
- Inputs sampled at edge e with `valid_in` = 1 appear with `valid_out` = 1 from edge e+L until edge e+L+1.
- Throughput is 1 per cycle. Results come out in input order, and consecutive valid inputs give consecutive valid outputs.
- Gaps in `valid_in` reproduce as identical gaps in `valid_out`.
- Every output is a registered value. No combinational path exists from inputs to outputs.

## Test plan
Defaults throughout (z=32, fi=16, width=10, int_bits=2).
1. **Reset:** hold `reset` = 0 with random inputs and `valid_in` = 1 -> all outputs 0. Release `reset` with `valid_in` = 0 for 10 cycles -> outputs stay 0.
2. **Basic sum:** all a = 0x080 (1.0), all w = 0x008 (0.0625), bias = 0, one valid pulse -> both neurons give a_out = 0x080 and adot_out = 0x080, with `valid_out` high for exactly 1 cycle, 6 cycles after sampling.
3. **Saturation and sign:** all a = 0x080. Neuron0 weights = 0x380 (-1.0), neuron1 weights = 0x080, bias = 0 -> neuron0 sum -16 saturates to 0x200, giving a_out = 0 and adot = 0. Neuron1 sum +16 saturates to 0x1FF, giving a_out = 0x1FF and adot = 0x080. Combined a_out_package = 0x7FC00; adot_out_package = 0x20000.
4. **Truncation:** a = 0x3FF (-1/128), w = 0x001 (1/128) -> each product floors to -1 LSB, so the tree sum is -16 LSB. Bias = 0x020 (0.25) -> s = 0x010, a_out = 0x010, adot = 0x080. The same case with a = 0x001 gives products 0, so a_out = 0x020.
5. **Streaming:** 3 back-to-back valid inputs (cases 2, 3, 4), a 2-cycle gap, then case 2 again -> outputs appear at cycles e+6, e+7, e+8, then a 2-cycle gap, then case 2. Values and order must match exactly.
6. **Reset mid-stream:** assert `reset` = 0 asynchronously (between edges) while 3 results are in flight -> `valid_out` and all outputs drop to 0 at once. After release with `valid_in` = 0, no stale result ever appears.

Source files
------------

// File: rtl/ff_processor_set.sv
// Feedforward neuron pipeline: lane-wise multiply, per-neuron adder tree, bias add and
// saturating ReLU. Emits a_out and its derivative adot_out with a travelling valid bit.
module ff_processor_set #(
  parameter int z        = 32,
  parameter int fi       = 16,
  parameter int width    = 10,
  parameter int int_bits = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [width*z-1:0]           a_in_package,
  input  logic [width*z-1:0]           wt_package,
  input  logic [width*(z/fi)-1:0]      bias_package,
  output logic [width*(z/fi)-1:0]      a_out_package,
  output logic [width*(z/fi)-1:0]      adot_out_package,
  output logic                         valid_out
);

  localparam int F  = width - 1 - int_bits;
  localparam int N  = z / fi;
  localparam int LG = $clog2(fi);
  localparam int AW = width + LG;
  localparam int SW = AW + 1;
  localparam int PW = 2 * width;
  localparam int NB = width * N;

  localparam logic signed [PW-1:0] PMAX = {{(width+1){1'b0}}, {(width-1){1'b1}}};
  localparam logic signed [PW-1:0] PMIN = {{(width+1){1'b1}}, {(width-1){1'b0}}};
  localparam logic signed [SW-1:0] SMAX = {{(LG+2){1'b0}}, {(width-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(LG+2){1'b1}}, {(width-1){1'b0}}};
  localparam logic [width-1:0]     ONE  = {{(width-1){1'b0}}, 1'b1} << F;

  function automatic logic [width-1:0] mul_sat(input logic [width-1:0] a, input logic [width-1:0] w);
    logic signed [PW-1:0] p;
    p = $signed({{width{a[width-1]}}, a}) * $signed({{width{w[width-1]}}, w});
    p = p >>> F;
    if (p > PMAX)      mul_sat = PMAX[width-1:0];
    else if (p < PMIN) mul_sat = PMIN[width-1:0];
    else               mul_sat = p[width-1:0];
  endfunction

  function automatic logic [width-1:0] sum_sat(input logic signed [SW-1:0] s);
    if (s > SMAX)      sum_sat = SMAX[width-1:0];
    else if (s < SMIN) sum_sat = SMIN[width-1:0];
    else               sum_sat = s[width-1:0];
  endfunction

  logic [width*z-1:0]     r_a;
  logic [width*z-1:0]     r_w;
  logic [NB-1:0]          r_bias [LG+2];
  logic [LG+1:0]          r_vld;
  logic [width-1:0]       r_prod [z];
  logic signed [AW-1:0]   r_tree [LG][z/2];
  logic [NB-1:0]          r_a_out;
  logic [NB-1:0]          r_adot_out;
  logic                   r_vld_out;

  logic [width-1:0]       w_prod [z];
  logic signed [AW-1:0]   w_src [LG][z];
  logic signed [SW-1:0]   w_s [N];
  logic [width-1:0]       w_sat [N];
  logic [NB-1:0]          w_a_nxt;
  logic [NB-1:0]          w_adot_nxt;

  always_comb begin
    for (int k = 0; k < z; k++) begin
      w_prod[k] = mul_sat(r_a[width*k +: width], r_w[width*k +: width]);
    end
  end

  // Level t of the tree reads sign-extended products (t=0) or the previous level's sums.
  always_comb begin
    for (int t = 0; t < LG; t++) begin
      for (int i = 0; i < z; i++) begin
        w_src[t][i] = '0;
      end
    end
    for (int i = 0; i < z; i++) begin
      w_src[0][i] = {{LG{r_prod[i][width-1]}}, r_prod[i]};
    end
    for (int t = 1; t < LG; t++) begin
      for (int i = 0; i < z/2; i++) begin
        w_src[t][i] = r_tree[t-1][i];
      end
    end
  end

  always_comb begin
    w_a_nxt    = '0;
    w_adot_nxt = '0;
    for (int n = 0; n < N; n++) begin
      w_s[n]   = {r_tree[LG-1][n][AW-1], r_tree[LG-1][n]}
               + {{(SW-width){r_bias[LG+1][width*n+width-1]}}, r_bias[LG+1][width*n +: width]};
      w_sat[n] = sum_sat(w_s[n]);
      if ($signed(w_sat[n]) > $signed({width{1'b0}})) begin
        w_a_nxt[width*n +: width]    = w_sat[n];
        w_adot_nxt[width*n +: width] = ONE;
      end else begin
        w_a_nxt[width*n +: width]    = {width{1'b0}};
        w_adot_nxt[width*n +: width] = {width{1'b0}};
      end
    end
  end

  // Input capture, multiply, adder tree and activation ranks; bias and valid ride alongside.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a        <= '0;
      r_w        <= '0;
      r_vld      <= '0;
      r_a_out    <= '0;
      r_adot_out <= '0;
      r_vld_out  <= 1'b0;
      for (int s = 0; s < LG+2; s++) r_bias[s] <= '0;
      for (int k = 0; k < z; k++) r_prod[k] <= '0;
      for (int t = 0; t < LG; t++) begin
        for (int i = 0; i < z/2; i++) r_tree[t][i] <= '0;
      end
    end else begin
      r_a       <= a_in_package;
      r_w       <= wt_package;
      r_vld     <= {r_vld[LG:0], valid_in};
      r_bias[0] <= bias_package;
      for (int s = 1; s < LG+2; s++) r_bias[s] <= r_bias[s-1];
      for (int k = 0; k < z; k++) r_prod[k] <= w_prod[k];
      for (int t = 0; t < LG; t++) begin
        for (int i = 0; i < z/2; i++) begin
          if (i < (z >> (t+1))) r_tree[t][i] <= w_src[t][2*i] + w_src[t][2*i+1];
          else                  r_tree[t][i] <= '0;
        end
      end
      r_a_out    <= w_a_nxt;
      r_adot_out <= w_adot_nxt;
      r_vld_out  <= r_vld[LG+1];
    end
  end

  assign a_out_package    = r_a_out;
  assign adot_out_package = r_adot_out;
  assign valid_out        = r_vld_out;

endmodule
